// File: rtl/snn_mac_bank.sv
// Multi-channel spike-gated accumulator bank for one SNN layer tile.
// Per-channel saturating/wrapping sums with sticky overflow, framed by a beat counter.
module snn_mac_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = 16,
  parameter int NUM_CH     = 4,
  parameter int FAN_IN     = 128,
  parameter int SATURATE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_spike,
  input  logic                            i_last,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    i_weights,
  output logic [NUM_CH*SUM_WIDTH-1:0]     o_sums,
  output logic [NUM_CH-1:0]               o_ovf,
  output logic [$clog2(FAN_IN+1)-1:0]     o_count,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_busy
);

  localparam int CW = $clog2(FAN_IN + 1);
  localparam int DW = DATA_WIDTH;
  localparam int SW = SUM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_CH*SW-1:0]       r_sums;
  logic [NUM_CH-1:0]          r_ovf;
  logic [CW-1:0]              r_count;

  logic                       w_accept;
  logic                       w_term;
  logic [CW-1:0]              w_cnt_inc;
  logic [NUM_CH-1:0][SW:0]    w_wide;
  logic [NUM_CH-1:0]          w_of;
  logic [NUM_CH*SW-1:0]       w_res;

  always_comb begin
    w_accept  = i_valid && (r_state == S_ACCUM);
    w_cnt_inc = r_count + CW'(1);
    w_term    = w_accept && (i_last || (w_cnt_inc == CW'(FAN_IN)));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_term)  w_state_nxt = S_DONE;
      S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One guard bit makes overflow visible as a mismatch of the top two bits.
  always_comb begin
    w_wide = '0;
    w_of   = '0;
    w_res  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wide[k] = {r_sums[k*SW+SW-1], r_sums[k*SW +: SW]}
                + {{(SW+1-DW){i_weights[k*DW+DW-1]}}, i_weights[k*DW +: DW]};
      w_of[k] = w_wide[k][SW] ^ w_wide[k][SW-1];
      if (w_of[k] && (SATURATE != 0)) begin
        w_res[k*SW +: SW] = w_wide[k][SW] ? {1'b1, {(SW-1){1'b0}}}
                                          : {1'b0, {(SW-1){1'b1}}};
      end else begin
        w_res[k*SW +: SW] = w_wide[k][SW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sums  <= '0;
      r_ovf   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && i_start) begin
        r_sums  <= '0;
        r_ovf   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= w_cnt_inc;
        if (i_spike) begin
          r_sums <= w_res;
          r_ovf  <= r_ovf | w_of;
        end
      end
    end
  end

  always_comb begin
    o_ready = (r_state == S_ACCUM);
    o_valid = (r_state == S_DONE);
    o_busy  = (r_state != S_IDLE);
    o_sums  = r_sums;
    o_ovf   = r_ovf;
    o_count = r_count;
  end

endmodule

// File: tb/tb_snn_mac_bank.sv
// Bench for snn_mac_bank: three shared-input instances (default, wide sat, wide wrap).
// Directed table frames, corner sequences, and random frames against an integer model.
module tb_snn_mac_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_spike = 1'b0;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_weights = '0;

  logic        rd_d, rd_s, rd_w;
  logic [63:0] s_d, s_s, s_w;
  logic [3:0]  ov_d, ov_s, ov_w;
  logic [7:0]  c_d;
  logic [9:0]  c_s, c_w;
  logic        v_d, v_s, v_w;
  logic        b_d, b_s_o, b_w_o;

  int n_tests = 0;
  int n_fail = 0;

  int b_w[512][4];
  bit b_s[512];

  always #5 clk = ~clk;

  snn_mac_bank u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid),
    .o_ready(rd_d), .i_spike(i_spike), .i_last(i_last),
    .i_weights(i_weights), .o_sums(s_d), .o_ovf(ov_d), .o_count(c_d),
    .o_valid(v_d), .i_ready(i_ready), .o_busy(b_d)
  );

  snn_mac_bank #(.FAN_IN(512), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid),
    .o_ready(rd_s), .i_spike(i_spike), .i_last(i_last),
    .i_weights(i_weights), .o_sums(s_s), .o_ovf(ov_s), .o_count(c_s),
    .o_valid(v_s), .i_ready(i_ready), .o_busy(b_s_o)
  );

  snn_mac_bank #(.FAN_IN(512), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid),
    .o_ready(rd_w), .i_spike(i_spike), .i_last(i_last),
    .i_weights(i_weights), .o_sums(s_w), .o_ovf(ov_w), .o_count(c_w),
    .o_valid(v_w), .i_ready(i_ready), .o_busy(b_w_o)
  );

  typedef struct {
    int         n;
    logic [7:0] spk;
    logic [31:0] wts;
    int         e0;
    int         e1;
    int         ecnt;
  } vec_t;

  vec_t tbl[5];

  function automatic int sk(input logic [63:0] s, input int k);
    logic signed [15:0] v;
    v = s[k*16 +: 16];
    return int'(v);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural reference: integer running sum with range clamp or modular fold.
  function automatic int ref_sum(input int fan, input bit sat, input int len,
                                 input int k, output bit ovf);
    int n;
    int acc;
    n = (len < fan) ? len : fan;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (b_s[i]) begin
        acc = acc + b_w[i][k];
        if (acc > 32767 || acc < -32768) begin
          ovf = 1'b1;
          if (sat) acc = (acc > 0) ? 32767 : -32768;
          else acc = (acc > 32767) ? acc - 65536 : acc + 65536;
        end
      end
    end
    return acc;
  endfunction

  task automatic do_reset();
    i_start = 0; i_valid = 0; i_last = 0; i_spike = 0; i_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic release_all();
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
  endtask

  task automatic drive_beat(input int idx, input bit last);
    i_valid = 1;
    i_spike = b_s[idx];
    for (int k = 0; k < 4; k++) i_weights[k*8 +: 8] = b_w[idx][k][7:0];
    i_last = last;
  endtask

  task automatic run_frame(input int len, input bit gaps);
    int idx;
    int guard;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    idx = 0;
    guard = 0;
    while (idx < len && guard < 4 * len + 100) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_valid = 0;
      end else begin
        drive_beat(idx, idx == len - 1);
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    if (idx < len) chk("frame_drive_timeout", idx, len);
    i_valid = 0; i_last = 0; i_spike = 0;
  endtask

  task automatic fill_const(input int len, input int w0, input int w1,
                            input int w2, input int w3);
    for (int i = 0; i < len; i++) begin
      b_s[i] = 1'b1;
      b_w[i][0] = w0; b_w[i][1] = w1; b_w[i][2] = w2; b_w[i][3] = w3;
    end
  endtask

  task automatic check_model(input int len);
    bit eo;
    int e;
    for (int k = 0; k < 4; k++) begin
      e = ref_sum(128, 1'b1, len, k, eo);
      chk("rnd_dflt_sum", sk(s_d, k), e);
      chk("rnd_dflt_ovf", ov_d[k], eo);
      e = ref_sum(512, 1'b1, len, k, eo);
      chk("rnd_sat_sum", sk(s_s, k), e);
      chk("rnd_sat_ovf", ov_s[k], eo);
      e = ref_sum(512, 1'b0, len, k, eo);
      chk("rnd_wrap_sum", sk(s_w, k), e);
      chk("rnd_wrap_ovf", ov_w[k], eo);
    end
    chk("rnd_dflt_cnt", c_d, (len < 128) ? len : 128);
    chk("rnd_sat_cnt", c_s, len);
    chk("rnd_wrap_cnt", c_w, len);
    chk("rnd_valid", {v_d, v_s, v_w}, 3'b111);
  endtask

  initial begin
    int acc_cnt;
    bit rdy_after;
    int len;
    int mode;

    tbl[0] = '{n: 5, spk: 8'h1F, wts: 32'h03030303, e0: 15, e1: 15, ecnt: 5};
    tbl[1] = '{n: 4, spk: 8'h05, wts: 32'h0000F90A, e0: 20, e1: -14, ecnt: 4};
    tbl[2] = '{n: 3, spk: 8'h00, wts: 32'hFFFFFFFF, e0: 0, e1: 0, ecnt: 3};
    tbl[3] = '{n: 8, spk: 8'hFF, wts: 32'h00007F80, e0: -1024, e1: 1016, ecnt: 8};
    tbl[4] = '{n: 1, spk: 8'h01, wts: 32'h0000FF01, e0: 1, e1: -1, ecnt: 1};

    repeat (3) @(negedge clk);
    chk("rst_sums", s_d, 0);
    chk("rst_ovf", ov_d, 0);
    chk("rst_count", c_d, 0);
    chk("rst_valid", v_d, 0);
    chk("rst_ready", rd_d, 0);
    chk("rst_busy", b_d, 0);
    rst = 0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        b_s[i] = tbl[t].spk[i];
        for (int k = 0; k < 4; k++) begin
          b_w[i][k] = int'($signed(tbl[t].wts[k*8 +: 8]));
        end
      end
      run_frame(tbl[t].n, 1'b0);
      chk("tbl_sum0", sk(s_d, 0), tbl[t].e0);
      chk("tbl_sum1", sk(s_d, 1), tbl[t].e1);
      chk("tbl_count", c_d, tbl[t].ecnt);
      chk("tbl_valid", v_d, 1);
      chk("tbl_ovf", ov_d, 0);
      release_all();
      chk("tbl_idle", {b_d, v_d}, 2'b00);
    end

    do_reset();
    fill_const(128, 127, -128, 0, 0);
    run_frame(128, 1'b0);
    chk("sat128_sum0", sk(s_s, 0), 16256);
    chk("sat128_sum1", sk(s_s, 1), -16384);
    chk("sat128_ovf", ov_s, 0);
    release_all();
    fill_const(300, 127, -128, 0, 0);
    run_frame(300, 1'b0);
    chk("sat300_sum0", sk(s_s, 0), 32767);
    chk("sat300_sum1", sk(s_s, 1), -32768);
    chk("sat300_ovf", ov_s, 4'b0011);
    chk("sat300_count", c_s, 300);
    chk("wrap300_sum0", sk(s_w, 0), -27436);
    chk("wrap300_sum1", sk(s_w, 1), 27136);
    chk("wrap300_ovf", ov_w, 4'b0011);

    do_reset();
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    acc_cnt = 0;
    rdy_after = 1'b1;
    for (int i = 0; i < 130; i++) begin
      if (i == 128) rdy_after = rd_d;
      if (rd_d) acc_cnt++;
      i_valid = 1; i_spike = 1; i_last = 0; i_weights = 32'h01010101;
      @(negedge clk);
    end
    i_valid = 0;
    chk("fanin_accepted", acc_cnt, 128);
    chk("fanin_ready_drop", rdy_after, 0);
    chk("fanin_count", c_d, 128);
    chk("fanin_sum0", sk(s_d, 0), 128);
    chk("fanin_valid", v_d, 1);

    for (int i = 0; i < 10; i++) begin
      i_start = i[0];
      i_valid = ~i[0];
      i_spike = 1;
      i_weights = 32'h7F7F7F7F;
      @(negedge clk);
      chk("bp_hold", {v_d, rd_d, c_d, s_d[15:0]}, {1'b1, 1'b0, 8'd128, 16'd128});
    end
    i_valid = 0;
    i_start = 1;
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    chk("hs_idle_busy", b_d, 0);
    chk("hs_idle_valid", v_d, 0);
    chk("hs_sums_held", sk(s_d, 0), 128);
    chk("hs_count_held", c_d, 128);
    @(negedge clk);
    i_start = 0;
    chk("restart_busy", {b_d, rd_d}, 2'b11);
    chk("restart_sums", s_d, 0);
    chk("restart_count", c_d, 0);

    do_reset();
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1; i_spike = 1; i_last = 0; i_weights = 32'h05050505;
      @(negedge clk);
    end
    i_valid = 0;
    chk("pre_rst_sum0", sk(s_d, 0), 15);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_outs", {s_d, ov_d, c_d, v_d, rd_d, b_d}, 0);
    fill_const(2, 5, 5, 5, 5);
    run_frame(2, 1'b0);
    chk("midrst_new_sum", sk(s_d, 0), 10);
    chk("midrst_new_cnt", c_d, 2);
    release_all();

    do_reset();
    for (int f = 0; f < 20; f++) begin
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 40) : $urandom_range(100, 320);
      for (int i = 0; i < len; i++) begin
        b_s[i] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) begin
          mode = (k + f) % 3;
          if (mode == 0) b_w[i][k] = int'($urandom_range(0, 255)) - 128;
          else if (mode == 1) b_w[i][k] = int'($urandom_range(100, 127));
          else b_w[i][k] = -int'($urandom_range(100, 128));
        end
      end
      run_frame(len, 1'b1);
      check_model(len);
      release_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
